// File: rtl/predicate_register_block.sv
// Per-warp, per-lane 1-bit predicate register file: one write port and two
// combinational read ports, with a per-lane enable on every port.

module predicate_lane #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IW-1:0]       widx,
  input  logic                wdata,
  input  logic [1:0]          ren,
  input  logic [1:0][IW-1:0]  ridx,
  output logic [1:0]          rdata
);
  // One lane's slice of every warp/register, flattened as {warp, reg}
  logic [DEPTH-1:0] bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     bits       <= '0;
    else if (we) bits[widx] <= wdata;
  end

  // No write bypass: reads see the stored value until the edge commits
  always_comb begin
    for (int p = 0; p < 2; p++) rdata[p] = ren[p] & bits[ridx[p]];
  end
endmodule

module predicate_register_block #(
  parameter int NUM_LANES = 16,
  parameter int NUM_WARPS = 16,
  parameter int NUM_PREGS = 16,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int AW = $clog2(NUM_PREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,  // active-high despite the suffix
  input  logic [WW-1:0]        warp_selector,
  input  logic [NUM_LANES-1:0] write_en,
  input  logic [AW-1:0]        waddr,
  input  logic wdata_0,  input  logic wdata_1,  input  logic wdata_2,  input  logic wdata_3,
  input  logic wdata_4,  input  logic wdata_5,  input  logic wdata_6,  input  logic wdata_7,
  input  logic wdata_8,  input  logic wdata_9,  input  logic wdata_10, input  logic wdata_11,
  input  logic wdata_12, input  logic wdata_13, input  logic wdata_14, input  logic wdata_15,
  input  logic [NUM_LANES-1:0] read_en_0,
  input  logic [AW-1:0]        raddr_0,
  input  logic [NUM_LANES-1:0] read_en_1,
  input  logic [AW-1:0]        raddr_1,
  output logic rdata_0_0,  output logic rdata_0_1,  output logic rdata_0_2,  output logic rdata_0_3,
  output logic rdata_0_4,  output logic rdata_0_5,  output logic rdata_0_6,  output logic rdata_0_7,
  output logic rdata_0_8,  output logic rdata_0_9,  output logic rdata_0_10, output logic rdata_0_11,
  output logic rdata_0_12, output logic rdata_0_13, output logic rdata_0_14, output logic rdata_0_15,
  output logic rdata_1_0,  output logic rdata_1_1,  output logic rdata_1_2,  output logic rdata_1_3,
  output logic rdata_1_4,  output logic rdata_1_5,  output logic rdata_1_6,  output logic rdata_1_7,
  output logic rdata_1_8,  output logic rdata_1_9,  output logic rdata_1_10, output logic rdata_1_11,
  output logic rdata_1_12, output logic rdata_1_13, output logic rdata_1_14, output logic rdata_1_15
);
  localparam int IW = WW + AW;

  logic [NUM_LANES-1:0]      wdata, rd0, rd1;
  logic [IW-1:0]             widx;
  logic [1:0][IW-1:0]        ridx;
  logic [NUM_LANES-1:0][1:0] rd_lane;

  assign wdata = {wdata_15, wdata_14, wdata_13, wdata_12, wdata_11, wdata_10, wdata_9, wdata_8,
                  wdata_7,  wdata_6,  wdata_5,  wdata_4,  wdata_3,  wdata_2,  wdata_1, wdata_0};

  // Warp selector retargets reads and writes alike; nothing is latched per warp
  assign widx    = {warp_selector, waddr};
  assign ridx[0] = {warp_selector, raddr_0};
  assign ridx[1] = {warp_selector, raddr_1};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    predicate_lane #(.DEPTH(NUM_WARPS*NUM_PREGS), .IW(IW)) u_lane (
      .clk   (clk),
      .rst   (rst_n),
      .we    (write_en[l]),
      .widx  (widx),
      .wdata (wdata[l]),
      .ren   ({read_en_1[l], read_en_0[l]}),
      .ridx  (ridx),
      .rdata (rd_lane[l])
    );
    assign rd0[l] = rd_lane[l][0];
    assign rd1[l] = rd_lane[l][1];
  end

  assign {rdata_0_15, rdata_0_14, rdata_0_13, rdata_0_12, rdata_0_11, rdata_0_10, rdata_0_9, rdata_0_8,
          rdata_0_7,  rdata_0_6,  rdata_0_5,  rdata_0_4,  rdata_0_3,  rdata_0_2,  rdata_0_1, rdata_0_0} = rd0;
  assign {rdata_1_15, rdata_1_14, rdata_1_13, rdata_1_12, rdata_1_11, rdata_1_10, rdata_1_9, rdata_1_8,
          rdata_1_7,  rdata_1_6,  rdata_1_5,  rdata_1_4,  rdata_1_3,  rdata_1_2,  rdata_1_1, rdata_1_0} = rd1;
endmodule

// File: tb/tb_predicate_register_block.sv
// Bench for predicate_register_block: vector table, hand-written corner
// sequences and random traffic against a warp/reg/lane array model.

module tb_predicate_register_block;
  logic        clk = 0;
  logic        rst_n;
  logic [3:0]  warp_selector, waddr, raddr_0, raddr_1;
  logic [15:0] write_en, wdata, read_en_0, read_en_1, rdata0, rdata1;

  int checks = 0, failures = 0;
  logic [15:0] model [16][16];  // model[warp][reg] = lane bits

  always #5 clk = ~clk;

  predicate_register_block dut (
    .clk(clk), .rst_n(rst_n), .warp_selector(warp_selector), .write_en(write_en), .waddr(waddr),
    .wdata_0(wdata[0]),   .wdata_1(wdata[1]),   .wdata_2(wdata[2]),   .wdata_3(wdata[3]),
    .wdata_4(wdata[4]),   .wdata_5(wdata[5]),   .wdata_6(wdata[6]),   .wdata_7(wdata[7]),
    .wdata_8(wdata[8]),   .wdata_9(wdata[9]),   .wdata_10(wdata[10]), .wdata_11(wdata[11]),
    .wdata_12(wdata[12]), .wdata_13(wdata[13]), .wdata_14(wdata[14]), .wdata_15(wdata[15]),
    .read_en_0(read_en_0), .raddr_0(raddr_0), .read_en_1(read_en_1), .raddr_1(raddr_1),
    .rdata_0_0(rdata0[0]),   .rdata_0_1(rdata0[1]),   .rdata_0_2(rdata0[2]),   .rdata_0_3(rdata0[3]),
    .rdata_0_4(rdata0[4]),   .rdata_0_5(rdata0[5]),   .rdata_0_6(rdata0[6]),   .rdata_0_7(rdata0[7]),
    .rdata_0_8(rdata0[8]),   .rdata_0_9(rdata0[9]),   .rdata_0_10(rdata0[10]), .rdata_0_11(rdata0[11]),
    .rdata_0_12(rdata0[12]), .rdata_0_13(rdata0[13]), .rdata_0_14(rdata0[14]), .rdata_0_15(rdata0[15]),
    .rdata_1_0(rdata1[0]),   .rdata_1_1(rdata1[1]),   .rdata_1_2(rdata1[2]),   .rdata_1_3(rdata1[3]),
    .rdata_1_4(rdata1[4]),   .rdata_1_5(rdata1[5]),   .rdata_1_6(rdata1[6]),   .rdata_1_7(rdata1[7]),
    .rdata_1_8(rdata1[8]),   .rdata_1_9(rdata1[9]),   .rdata_1_10(rdata1[10]), .rdata_1_11(rdata1[11]),
    .rdata_1_12(rdata1[12]), .rdata_1_13(rdata1[13]), .rdata_1_14(rdata1[14]), .rdata_1_15(rdata1[15])
  );

  typedef struct {
    logic [3:0]  wwarp, wa;
    logic [15:0] we, wd;
    logic [3:0]  rwarp, ra0;
    logic [15:0] re0;
    logic [3:0]  ra1;
    logic [15:0] re1, e0, e1;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [3:0] w, input logic [3:0] a, input logic [15:0] en);
    return model[w][a] & en;
  endfunction

  task automatic clear_model();
    for (int w = 0; w < 16; w++) for (int r = 0; r < 16; r++) model[w][r] = '0;
  endtask

  task automatic check_reads(input string name);
    #1;
    check({name, ".p0"}, rdata0, exp_rd(warp_selector, raddr_0, read_en_0));
    check({name, ".p1"}, rdata1, exp_rd(warp_selector, raddr_1, read_en_1));
  endtask

  // Commit whatever write is on the inputs at the next edge, then mirror it
  task automatic do_write();
    @(posedge clk); #1;
    for (int l = 0; l < 16; l++) if (write_en[l]) model[warp_selector][waddr][l] = wdata[l];
  endtask

  task automatic pulse_reset();
    rst_n = 1; clear_model();
    @(posedge clk); #1;
    rst_n = 0;
  endtask

  initial begin
    rst_n = 1; warp_selector = 0; waddr = 0; wdata = 0; write_en = 0;
    read_en_0 = 0; read_en_1 = 0; raddr_0 = 0; raddr_1 = 0;
    clear_model();

    // 1: reset clears storage
    @(posedge clk); #1; rst_n = 0;
    read_en_0 = 16'hFFFF; read_en_1 = 16'hFFFF;
    for (int r = 0; r < 16; r++) begin
      raddr_0 = r[3:0]; raddr_1 = 4'(15 - r);
      #1; check("reset_p0", rdata0, 16'h0); check("reset_p1", rdata1, 16'h0);
    end

    // 2: full write/read sweep
    for (int w = 0; w < 16; w++) for (int r = 0; r < 16; r++) begin
      warp_selector = w[3:0]; waddr = r[3:0]; write_en = 16'hFFFF; wdata = 16'hFFFF;
      do_write(); write_en = 0;
      raddr_0 = r[3:0]; raddr_1 = r[3:0];
      read_en_0 = 16'hFFFF; read_en_1 = 0; #1;
      check("sweep_p0only_p0", rdata0, 16'hFFFF); check("sweep_p0only_p1", rdata1, 16'h0);
      read_en_0 = 0; read_en_1 = 16'hFFFF; #1;
      check("sweep_p1only_p0", rdata0, 16'h0); check("sweep_p1only_p1", rdata1, 16'hFFFF);
      read_en_0 = 16'hFFFF; #1;
      check("sweep_both_p0", rdata0, 16'hFFFF); check("sweep_both_p1", rdata1, 16'hFFFF);
    end

    // 3-5 plus extras: sequential vector table from a clean state
    pulse_reset();
    tbl[0] = '{4'd3, 4'd5, 16'h00FF, 16'hFFFF, 4'd3, 4'd5, 16'hFFFF, 4'd5, 16'hFFFF, 16'h00FF, 16'h00FF};
    tbl[1] = '{4'd2, 4'd7, 16'hFFFF, 16'hFFFF, 4'd4, 4'd7, 16'hFFFF, 4'd7, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[2] = '{4'd0, 4'd0, 16'h0000, 16'hFFFF, 4'd2, 4'd7, 16'hFFFF, 4'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{4'd0, 4'd1, 16'hFFFF, 16'hFFFF, 4'd0, 4'd1, 16'hF0F0, 4'd2, 16'hFFFF, 16'hF0F0, 16'h0000};
    tbl[4] = '{4'd0, 4'd2, 16'hFFFF, 16'h0000, 4'd0, 4'd1, 16'hFFFF, 4'd2, 16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[5] = '{4'd0, 4'd1, 16'h000F, 16'h0000, 4'd0, 4'd1, 16'hFFFF, 4'd1, 16'hFFFF, 16'hFFF0, 16'hFFF0};
    tbl[6] = '{4'd3, 4'd5, 16'hFF00, 16'hAAAA, 4'd3, 4'd5, 16'hFFFF, 4'd5, 16'h0F0F, 16'hAAFF, 16'h0A0F};
    for (int i = 0; i < 7; i++) begin
      warp_selector = tbl[i].wwarp; waddr = tbl[i].wa; write_en = tbl[i].we; wdata = tbl[i].wd;
      do_write(); write_en = 0;
      warp_selector = tbl[i].rwarp;
      raddr_0 = tbl[i].ra0; read_en_0 = tbl[i].re0; raddr_1 = tbl[i].ra1; read_en_1 = tbl[i].re1;
      #1;
      check($sformatf("vec%0d_p0", i), rdata0, tbl[i].e0);
      check($sformatf("vec%0d_p1", i), rdata1, tbl[i].e1);
    end

    // 6: no read bypass, then asynchronous reset wins over a held write
    warp_selector = 4'd5; waddr = 4'd9; raddr_0 = 4'd9; raddr_1 = 4'd9;
    write_en = 16'hFFFF; wdata = 16'hFFFF; read_en_0 = 16'hFFFF; read_en_1 = 16'hFFFF;
    #1; check("nobypass_before", rdata0, 16'h0000);
    @(posedge clk); #1; check("nobypass_after", rdata0, 16'hFFFF);
    #2; rst_n = 1; #1;
    check("async_rst_p0", rdata0, 16'h0000); check("async_rst_p1", rdata1, 16'h0000);
    @(posedge clk); #1;
    check("rst_over_write_p0", rdata0, 16'h0000); check("rst_over_write_p1", rdata1, 16'h0000);
    rst_n = 0; write_en = 0; clear_model();
    check_reads("post_rst");

    // Random traffic over a narrow window of warps/regs for frequent collisions
    for (int i = 0; i < 500; i++) begin
      warp_selector = 4'($urandom_range(0, 3)); waddr = 4'($urandom_range(0, 3));
      write_en = 16'($urandom); wdata = 16'($urandom);
      raddr_0 = 4'($urandom_range(0, 3)); raddr_1 = 4'($urandom_range(0, 3));
      read_en_0 = 16'($urandom); read_en_1 = 16'($urandom);
      check_reads("rand_pre");
      do_write();
      check_reads("rand_post");
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1; clear_model();
        check_reads("rand_rst");
        @(posedge clk); #1; rst_n = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/predicate_register_block.md
Name: predicate_register_block

Overview:
Per-warp, per-lane 1-bit predicate register file for a 16-lane SIMT core. It holds 16 warps × 16 predicate registers × 16 lanes, for 4096 bits in total. The block has one write port and two independent combinational read ports. Each lane has its own enable on every port. It sits beside the vector register file and feeds predicate bits to the lane execution units.

Parameters:
NUM_LANES, 16, number of SIMD lanes. Fixes the width of each enable vector and the count of wdata/rdata ports.
NUM_WARPS, 16, number of warp contexts. warp_selector width is log2(NUM_WARPS) = 4.
NUM_PREGS, 16, predicate registers per warp per lane. Address width is log2(NUM_PREGS) = 4.

Ports:
clk  input  1  clock; all writes happen on the rising edge.
rst_n  input  1  asynchronous reset, active-HIGH despite the suffix (1 = reset asserted).
warp_selector  input  4  selects the warp context for both writes and reads.
write_en  input  16  per-lane write enable; bit l controls lane l.
waddr  input  4  predicate register address for the write.
wdata_0 .. wdata_15  input  1 each  write data for lanes 0..15.
read_en_0  input  16  per-lane enable for read port 0.
raddr_0  input  4  register address for read port 0.
read_en_1  input  16  per-lane enable for read port 1.
raddr_1  input  4  register address for read port 1.
rdata_0_0 .. rdata_0_15  output  1 each  read port 0 data for lanes 0..15.
rdata_1_0 .. rdata_1_15  output  1 each  read port 1 data for lanes 0..15.

Behaviour:
- Storage: mem[w][r][l], 1 bit each, with w = warp, r = register, l = lane.
- Reset: while rst_n = 1, all 4096 bits clear to 0 immediately, without waiting for a clock edge.
  - Reset has priority over any write in the same cycle.
  - Reset asserted mid-operation discards all stored state.
- Write: at posedge clk with reset deasserted, for each lane l with write_en[l] = 1, mem[warp_selector][waddr][l] <= wdata_l.
  - Lanes whose enable is 0 are unchanged.
  - Other warps and registers are never disturbed.
- Read (both ports, combinational, zero latency):
  - rdata_p_l = mem[warp_selector][raddr_p][l] when read_en_p[l] = 1.
  - When read_en_p[l] = 0, rdata_p_l = 0.
  - Outputs settle within the same cycle as an address or enable change.
- Both ports are fully independent. They may read the same or different addresses at once, with any enable mix.
- Read-during-write to the same location: no bypass. Before the edge the read returns the old value; after the edge it returns the new value.
- Warp isolation: changing warp_selector immediately retargets both reads and writes. No state is tied to the previous warp.
- Address decode is full; there are no out-of-range addresses, so no wrap-around handling is needed.
- Reset values of outputs: all rdata are 0, since storage is 0 or the read is disabled.

Test Plan:
1. Reset clears storage:
   - Stimulus: assert rst_n = 1 for 1 cycle, then deassert. Read all regs of warp 0 with read_en_0 = read_en_1 = 16'hFFFF.
   - Required response: every rdata = 0.
2. Full write/read sweep:
   - Stimulus: for each warp 0..15 and each reg 0..15, write_en = 16'hFFFF with all wdata = 1. At the next negedge, read via port 0 only, then port 1 only, then both ports with raddr_0 = raddr_1 = waddr.
   - Required response: all 16 lanes read 1 on each enabled port; disabled-port outputs read 0.
3. Per-lane write enable:
   - Stimulus: write_en = 16'h00FF, wdata_l = 1 for all lanes, to warp 3 reg 5. Then read warp 3 reg 5 with all lanes enabled.
   - Required response: lanes 0..7 = 1, lanes 8..15 = 0.
4. Warp isolation:
   - Stimulus: write 1 to warp 2 reg 7 all lanes, then switch warp_selector to 4 and read reg 7.
   - Required response: all 0. Switching back to warp 2 returns all 1.
5. Dual-port independence:
   - Stimulus: reg 1 = all 1, reg 2 = all 0. Read with raddr_0 = 1, raddr_1 = 2, read_en_0 = 16'hF0F0, read_en_1 = 16'hFFFF.
   - Required response: port 0 lanes 4-7 and 12-15 = 1, others = 0; port 1 all 0.
6. No read bypass:
   - Stimulus: with reg 9 = 0, hold write_en = 16'hFFFF, wdata = 1, waddr = raddr_0 = 9.
   - Required response: rdata_0_* = 0 before the posedge and 1 after it. Asserting reset at any time then forces all outputs to 0 asynchronously.
